// File: rtl/sc_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sc_bus_pkg : shared IDs, FSM encoding and word size for the RAM bus   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sc_bus_pkg;

  localparam logic [1:0] MST_CPU  = 2'd0;
  localparam logic [1:0] MST_LINK = 2'd1;
  localparam logic [1:0] MST_COP  = 2'd2;
  localparam logic [1:0] MST_NONE = 2'd3;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sc_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sc_arb_pick : link-first winner select with starvation guard, RR     |
// | between CPU and coprocessor. Rev 1.0                                 |
// +----------------------------------------------------------------------+
module sc_arb_pick
  import sc_bus_pkg::*;
#(
  parameter int LINK_MAX = 4,
  parameter int CNT_W    = 3
) (
  input  logic [2:0]       valid,
  input  logic [1:0]       rr_last,
  input  logic [CNT_W-1:0] link_cnt,
  output logic [1:0]       win_id,
  output logic             win_valid
);

  logic others;
  logic link_ok;

  always_comb begin
    win_id    = MST_NONE;
    win_valid = |valid;
    others    = valid[MST_CPU] | valid[MST_COP];
    // The link is only held back once it has used its burst while someone waits.
    link_ok   = valid[MST_LINK] && ((link_cnt < CNT_W'(LINK_MAX)) || !others);
    if (link_ok) begin
      win_id = MST_LINK;
    end else if (valid[MST_CPU] && valid[MST_COP]) begin
      win_id = (rr_last == MST_COP) ? MST_CPU : MST_COP;
    end else if (valid[MST_CPU]) begin
      win_id = MST_CPU;
    end else if (valid[MST_COP]) begin
      win_id = MST_COP;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sc_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sc_mem_arbiter : three-master arbiter onto one single-port data RAM  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sc_mem_arbiter
  import sc_bus_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int RAM_WORDS = 1024,
  parameter int RAM_LAT   = 1,
  parameter int LINK_MAX  = 4
) (
  input  logic                clk_sc,
  input  logic                reset,
  input  logic [2:0]          m_valid,
  input  logic [3*ADDR_W-1:0] m_addr,
  input  logic [95:0]         m_wdata,
  input  logic [11:0]         m_wstrb,
  output logic [2:0]          m_ready,
  output logic [31:0]         m_rdata,
  output logic                ram_en,
  output logic [3:0]          ram_we,
  output logic [ADDR_W-3:0]   ram_addr,
  output logic [31:0]         ram_wdata,
  input  logic [31:0]         ram_rdata,
  output logic [1:0]          grant_id,
  output logic                bus_err
);

  localparam int OFF_W = $clog2(WORD_BYTES);
  localparam int AW    = ADDR_W - OFF_W;
  localparam int CNT_W = $clog2(LINK_MAX + 1);
  localparam int LAT_W = 2;

  state_t           state;
  logic [1:0]       rr_last;
  logic [CNT_W-1:0] link_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic             req_write;
  logic             req_oor;

  logic [1:0]       win_id;
  logic             win_valid;
  logic [AW-1:0]    sel_word;
  logic [31:0]      sel_wdata;
  logic [3:0]       sel_wstrb;
  logic             sel_oor;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = &{1'b0, m_addr[OFF_W-1:0], m_addr[ADDR_W+OFF_W-1:ADDR_W],
                             m_addr[2*ADDR_W+OFF_W-1:2*ADDR_W]};

  sc_arb_pick #(
    .LINK_MAX (LINK_MAX),
    .CNT_W    (CNT_W)
  ) u_pick (
    .valid     (m_valid),
    .rr_last   (rr_last),
    .link_cnt  (link_cnt),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  always_comb begin
    sel_word  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < 3; i++) begin
      if (win_id == 2'(i)) begin
        sel_word  = m_addr[i*ADDR_W+OFF_W +: AW];
        sel_wdata = m_wdata[i*32 +: 32];
        sel_wstrb = m_wstrb[i*4 +: 4];
      end
    end
    sel_oor = 32'(sel_word) >= 32'(RAM_WORDS);
  end

  // Read data comes straight from the RAM in RESP to keep the RAM_LAT+1 latency.
  assign m_rdata = (state == ST_RESP && !req_write && !req_oor) ? ram_rdata : 32'h0;

  always_ff @(posedge clk_sc) begin
    if (reset) begin
      state     <= ST_IDLE;
      m_ready   <= 3'b000;
      ram_en    <= 1'b0;
      ram_we    <= 4'h0;
      ram_addr  <= '0;
      ram_wdata <= 32'h0;
      grant_id  <= MST_NONE;
      bus_err   <= 1'b0;
      rr_last   <= MST_COP;
      link_cnt  <= '0;
      lat_cnt   <= '0;
      req_write <= 1'b0;
      req_oor   <= 1'b0;
    end else begin
      ram_en  <= 1'b0;
      ram_we  <= 4'h0;
      m_ready <= 3'b000;
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            grant_id  <= win_id;
            req_write <= |sel_wstrb;
            req_oor   <= sel_oor;
            ram_en    <= !sel_oor;
            ram_we    <= sel_oor ? 4'h0 : sel_wstrb;
            ram_addr  <= sel_word;
            ram_wdata <= sel_wdata;
            if (win_id == MST_LINK) begin
              if (link_cnt != CNT_W'(LINK_MAX)) link_cnt <= link_cnt + 1'b1;
            end else begin
              link_cnt <= '0;
              rr_last  <= win_id;
            end
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (req_oor) begin
            bus_err <= 1'b1;
            m_ready <= 3'b001 << grant_id;
            state   <= ST_RESP;
          end else if (RAM_LAT == 1) begin
            m_ready <= 3'b001 << grant_id;
            state   <= ST_RESP;
          end else begin
            lat_cnt <= LAT_W'(RAM_LAT - 1);
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == LAT_W'(1)) begin
            m_ready <= 3'b001 << grant_id;
            state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          grant_id <= MST_NONE;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sc_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sc_mem_arbiter : directed vectors and arbitration sequences       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_sc_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT 1: 13-bit addresses so word 1024 is reachable, RAM_LAT=1
  logic        reset1;
  logic [2:0]  m_valid1;
  logic [38:0] m_addr1;
  logic [95:0] m_wdata1;
  logic [11:0] m_wstrb1;
  logic [2:0]  m_ready1;
  logic [31:0] m_rdata1;
  logic        ram_en1;
  logic [3:0]  ram_we1;
  logic [10:0] ram_addr1;
  logic [31:0] ram_wdata1;
  logic [31:0] ram_rdata1;
  logic [1:0]  grant_id1;
  logic        bus_err1;

  sc_mem_arbiter #(.ADDR_W(13), .RAM_WORDS(1024), .RAM_LAT(1), .LINK_MAX(4)) dut1 (
    .clk_sc(clk), .reset(reset1), .m_valid(m_valid1), .m_addr(m_addr1),
    .m_wdata(m_wdata1), .m_wstrb(m_wstrb1), .m_ready(m_ready1), .m_rdata(m_rdata1),
    .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
    .ram_rdata(ram_rdata1), .grant_id(grant_id1), .bus_err(bus_err1)
  );

  // DUT 3: default address width, RAM_LAT=3
  logic        reset3;
  logic [2:0]  m_valid3;
  logic [35:0] m_addr3;
  logic [95:0] m_wdata3;
  logic [11:0] m_wstrb3;
  logic [2:0]  m_ready3;
  logic [31:0] m_rdata3;
  logic        ram_en3;
  logic [3:0]  ram_we3;
  logic [9:0]  ram_addr3;
  logic [31:0] ram_wdata3;
  logic [31:0] ram_rdata3;
  logic [1:0]  grant_id3;
  logic        bus_err3;

  sc_mem_arbiter #(.ADDR_W(12), .RAM_WORDS(1024), .RAM_LAT(3), .LINK_MAX(4)) dut3 (
    .clk_sc(clk), .reset(reset3), .m_valid(m_valid3), .m_addr(m_addr3),
    .m_wdata(m_wdata3), .m_wstrb(m_wstrb3), .m_ready(m_ready3), .m_rdata(m_rdata3),
    .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
    .ram_rdata(ram_rdata3), .grant_id(grant_id3), .bus_err(bus_err3)
  );

  // Byte-merging RAM model, one-cycle read latency
  logic [31:0] mem1 [0:2047];
  always @(posedge clk) begin
    logic [31:0] w;
    if (ram_en1) begin
      w = mem1[ram_addr1];
      ram_rdata1 <= w;
      for (int b = 0; b < 4; b++)
        if (ram_we1[b]) w[b*8 +: 8] = ram_wdata1[b*8 +: 8];
      mem1[ram_addr1] = w;
    end
  end

  // Three-cycle read pipeline returning an address-derived pattern
  logic [31:0] d1, d2;
  always @(posedge clk) begin
    d1         <= ram_en3 ? (32'hA500_0000 | 32'(ram_addr3)) : 32'h0;
    d2         <= d1;
    ram_rdata3 <= d2;
  end

  // Masters must hold m_valid until their m_ready
  logic [2:0] pv1, pr1;
  logic       prst1;
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      if (!reset1 && !prst1 && pv1[i] && !m_valid1[i])
        assert (pr1[i]) else $error("m_valid[%0d] dropped before m_ready", i);
    pv1   <= m_valid1;
    pr1   <= m_ready1;
    prst1 <= reset1;
  end

  typedef struct {
    int          id;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        exp_en;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];
  int   tie_exp[10]  = '{1, 0, 1, 2, 1, 0, 0, 0, 0, 0};
  int   starv_exp[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic rst1;
    reset1   = 1'b1;
    m_valid1 = 3'b000;
    tick;
    tick;
    reset1 = 1'b0;
  endtask

  task automatic do_txn(input int k, input vec_t v);
    logic [12:0] a;
    int n;
    a = v.addr;
    m_addr1[v.id*13 +: 13]  = v.addr;
    m_wdata1[v.id*32 +: 32] = v.wdata;
    m_wstrb1[v.id*4 +: 4]   = v.wstrb;
    m_valid1[v.id]          = 1'b1;
    tick;
    chk($sformatf("v%0d grant_id", k), 32'(grant_id1), 32'(v.id));
    chk($sformatf("v%0d ram_en", k), 32'(ram_en1), 32'(v.exp_en));
    if (v.exp_en) begin
      chk($sformatf("v%0d ram_addr", k), 32'(ram_addr1), 32'(a[12:2]));
      chk($sformatf("v%0d ram_we", k), 32'(ram_we1), 32'(v.wstrb));
      if (v.wstrb != 4'h0) chk($sformatf("v%0d ram_wdata", k), ram_wdata1, v.wdata);
    end
    n = 0;
    while (n < 8) begin
      tick;
      n++;
      if (m_ready1 != 3'b000) break;
    end
    chk($sformatf("v%0d latency", k), 32'(n), 32'd1);
    chk($sformatf("v%0d m_ready", k), 32'(m_ready1), 32'(3'b001 << v.id));
    chk($sformatf("v%0d m_rdata", k), m_rdata1, v.exp_rdata);
    tick;
    m_valid1[v.id] = 1'b0;
    chk($sformatf("v%0d grant_id idle", k), 32'(grant_id1), 32'd3);
  endtask

  // Masters in 'drops' fall silent for the cycle after their m_ready, others re-request at once
  task automatic run_seq(input string tag, input logic [2:0] drops, input int n,
                         input int exp_g[10]);
    logic [2:0] down;
    logic [2:0] rprev;
    int got;
    int cyc;
    int idx;
    down  = 3'b000;
    rprev = 3'b000;
    got   = 0;
    cyc   = 0;
    while (got < n && cyc < 300) begin
      tick;
      cyc++;
      for (int i = 0; i < 3; i++) begin
        if (down[i]) begin
          m_valid1[i] = 1'b1;
          down[i]     = 1'b0;
        end else if (rprev[i] && drops[i]) begin
          m_valid1[i] = 1'b0;
          down[i]     = 1'b1;
        end
      end
      rprev = m_ready1;
      checks++;
      if (!$onehot0(m_ready1)) begin
        errors++;
        $display("FAIL %s onehot0: m_ready=%b", tag, m_ready1);
      end
      if (m_ready1 != 3'b000) begin
        idx = m_ready1[1] ? 1 : (m_ready1[2] ? 2 : 0);
        chk($sformatf("%s grant %0d", tag, got), 32'(idx), 32'(exp_g[got]));
        got++;
      end
    end
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d grants expected %0d", tag, got, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    m_addr1 = '0; m_wdata1 = '0; m_wstrb1 = '0; m_valid1 = 3'b000; reset1 = 1'b1;
    m_addr3 = '0; m_wdata3 = '0; m_wstrb3 = '0; m_valid3 = 3'b000; reset3 = 1'b1;
    for (int i = 0; i < 2048; i++) mem1[i] = 32'h0;
    mem1[4]    = 32'hDEAD_BEEF;
    mem1[32]   = 32'h1122_3344;
    mem1[1023] = 32'h0BAD_F00D;

    vecs[0] = '{0, 13'h0010, 32'h0000_0000, 4'h0, 1'b1, 32'hDEAD_BEEF};
    vecs[1] = '{0, 13'h0040, 32'hCAFE_BABE, 4'hF, 1'b1, 32'h0000_0000};
    vecs[2] = '{2, 13'h0040, 32'h0000_0000, 4'h0, 1'b1, 32'hCAFE_BABE};
    vecs[3] = '{1, 13'h0080, 32'h0000_AB00, 4'h2, 1'b1, 32'h0000_0000};
    vecs[4] = '{0, 13'h0080, 32'h0000_0000, 4'h0, 1'b1, 32'h1122_AB44};
    vecs[5] = '{2, 13'h0080, 32'h7700_0000, 4'h8, 1'b1, 32'h0000_0000};
    vecs[6] = '{1, 13'h0080, 32'h0000_0000, 4'h0, 1'b1, 32'h7722_AB44};
    vecs[7] = '{2, 13'h1000, 32'h0000_0000, 4'h0, 1'b0, 32'h0000_0000};
    vecs[8] = '{0, 13'h0FFC, 32'h0000_0000, 4'h0, 1'b1, 32'h0BAD_F00D};

    rst1;
    chk("reset m_ready", 32'(m_ready1), 32'd0);
    chk("reset m_rdata", m_rdata1, 32'h0);
    chk("reset ram_en", 32'(ram_en1), 32'd0);
    chk("reset ram_we", 32'(ram_we1), 32'd0);
    chk("reset ram_addr", 32'(ram_addr1), 32'd0);
    chk("reset ram_wdata", ram_wdata1, 32'h0);
    chk("reset grant_id", 32'(grant_id1), 32'd3);
    chk("reset bus_err", 32'(bus_err1), 32'd0);

    for (int k = 0; k < 9; k++) begin
      if (k == 7) chk("bus_err before oor", 32'(bus_err1), 32'd0);
      do_txn(k, vecs[k]);
    end
    chk("bus_err sticky", 32'(bus_err1), 32'd1);
    rst1;
    chk("bus_err after reset", 32'(bus_err1), 32'd0);

    // three-way tie from reset
    m_addr1  = {13'h0008, 13'h0004, 13'h0000};
    m_wstrb1 = 12'h000;
    reset1   = 1'b1;
    m_valid1 = 3'b111;
    tick;
    tick;
    reset1 = 1'b0;
    run_seq("tie", 3'b111, 6, tie_exp);
    rst1;

    // link continuously valid against a waiting CPU
    m_valid1 = 3'b011;
    run_seq("starve", 3'b001, 10, starv_exp);
    rst1;

    // abort during WAIT with RAM_LAT=3, then a clean access
    tick;
    reset3 = 1'b0;
    m_addr3[11:0] = 12'h020;
    m_valid3[0]   = 1'b1;
    tick;
    chk("lat3 ram_en issue", 32'(ram_en3), 32'd1);
    tick;
    reset3   = 1'b1;
    m_valid3 = 3'b000;
    tick;
    chk("abort m_ready", 32'(m_ready3), 32'd0);
    chk("abort grant_id", 32'(grant_id3), 32'd3);
    chk("abort ram_en", 32'(ram_en3), 32'd0);
    reset3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("abort quiet %0d", i), 32'(m_ready3), 32'd0);
    end
    m_addr3[11:0] = 12'h034;
    m_valid3[0]   = 1'b1;
    n = 0;
    while (n < 12) begin
      tick;
      n++;
      if (m_ready3 != 3'b000) break;
    end
    chk("lat3 latency", 32'(n), 32'd4);
    chk("lat3 m_ready", 32'(m_ready3), 32'd1);
    chk("lat3 m_rdata", m_rdata3, 32'hA500_000D);
    tick;
    m_valid3 = 3'b000;
    chk("lat3 grant_id idle", 32'(grant_id3), 32'd3);
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sc_mem_arbiter.md
Name: sc_mem_arbiter

Overview:
- Shares one single-port data RAM between three masters: CPU (picorv32 native memory interface), ISO14443 link frame-buffer DMA, and coprocessor operand DMA.
- Sits between bus_interface/mmi_top and the RAM.
- The link has real-time priority, bounded by a starvation guard. CPU and coprocessor alternate round-robin.
- Every transfer is a single 32-bit word access with byte strobes.

Parameters:
- ADDR_W, 12, byte-address width; word index is addr[ADDR_W-1:2].
- RAM_WORDS, 1024, implemented words; word index >= RAM_WORDS is out of range.
- RAM_LAT, 1, RAM read latency in cycles (1..3).
- LINK_MAX, 4, maximum consecutive link grants while another master is pending.

Ports:
- clk_sc  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- m_valid  in  3  request per master; [0]=CPU, [1]=link, [2]=coprocessor.
- m_addr  in  3*ADDR_W  byte addresses, packed by master index.
- m_wdata  in  96  write data, packed.
- m_wstrb  in  12  byte strobes, packed; 0 = read.
- m_ready  out  3  one-cycle completion pulse per master.
- m_rdata  out  32  read data, shared; valid when any m_ready bit is high.
- ram_en  out  1  RAM access enable.
- ram_we  out  4  RAM byte write enables.
- ram_addr  out  ADDR_W-2  RAM word index.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, RAM_LAT cycles after ram_en.
- grant_id  out  2  master currently owning the RAM; 3 = none.
- bus_err  out  1  sticky out-of-range flag; cleared only by reset.

Behaviour:
- Reset values: m_ready=0, m_rdata=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, grant_id=3, bus_err=0, rr_last=coprocessor (so the CPU wins the first tie), link_cnt=0, state=IDLE.
- Reset asserted mid-access aborts the access with no m_ready pulse. It takes effect in the same clock edge.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any m_valid bit is set, register the winner, its address, wdata and wstrb, set grant_id, and go to ISSUE. Otherwise stay in IDLE.
- Arbitration priority:
  - Link wins if m_valid[1] and (link_cnt < LINK_MAX or no other master valid).
  - Otherwise the valid one of CPU/coprocessor wins; if both are valid, the one not equal to rr_last wins.
  - If link_cnt == LINK_MAX and another master is valid, the link is skipped.
- link_cnt update: increments on each link grant, saturating at LINK_MAX; resets to 0 on any non-link grant.
- rr_last updates only on CPU or coprocessor grants.
- ISSUE, in-range address: ram_en=1 for exactly one cycle; ram_we=wstrb; ram_addr and ram_wdata driven from the registered request. Go to WAIT with counter=RAM_LAT-1, or go straight to RESP if RAM_LAT==1.
- ISSUE, out-of-range address: ram_en stays 0, bus_err is set, and the state goes to RESP with m_rdata forced to 0.
- WAIT: decrement the counter; at 0 go to RESP.
- RESP: pulse m_ready[grant_id] for one cycle. m_rdata is ram_rdata for reads and 0 for writes. Then go to IDLE with grant_id=3.
- Latency from IDLE sampling m_valid to m_ready is RAM_LAT+1 cycles, for reads and writes alike.
- Master rules:
  - Masters hold m_valid and their payload until their m_ready.
  - Masters may drop or re-raise m_valid in the cycle after m_ready.
  - IDLE never samples a master in the same cycle as that master's m_ready, so there is no duplicate grant.
- Request changes: the payload is captured in IDLE, so later changes to m_addr or m_wdata are ignored. Dropping m_valid before m_ready is illegal; the bench flags it with an assertion.
- Back-to-back accesses cost one IDLE cycle each, giving throughput of one access per RAM_LAT+2 cycles.
- At most one m_ready bit is ever high (onehot0).

Decomposition:
- Shared package sc_bus_pkg holds:
  - master ID constants MST_CPU=0, MST_LINK=1, MST_COP=2, MST_NONE=3;
  - FSM state encoding;
  - the WORD_BYTES constant.
- One sub-module, sc_arb_pick: combinational winner selection from m_valid, rr_last, link_cnt and LINK_MAX. It outputs the winner ID and a valid flag.
- The main module holds the FSM, request registers and counters.

Test Plan:
- Single CPU read: CPU read of 0x010 holding 0xDEADBEEF, RAM_LAT=1 -> ram_en with ram_addr=4 one cycle after IDLE; m_ready[0] with m_rdata=0xDEADBEEF two cycles after m_valid.
- Three-way tie: all three masters valid from reset -> grant order link, CPU, link, coprocessor, link, CPU…; each master receives exactly one m_ready per request.
- Starvation guard: link continuously valid and CPU valid, LINK_MAX=4 -> four link grants, then one CPU grant, then link resumes with link_cnt=1.
- Byte-write merge: link write wstrb=0b0010, wdata=0x0000AB00 to word 0x20 holding 0x11223344, then CPU readback -> 0x1122AB44.
- Out of range: coprocessor read of address 0x1000 (word 1024) with RAM_WORDS=1024 -> no ram_en; m_ready[2] with rdata=0; bus_err=1 and stays set.
- Reset mid-access: RAM_LAT=3, reset asserted during WAIT -> next cycle no m_ready, grant_id=3, ram_en=0; a new CPU request after reset completes normally in 4 cycles.
